// File: rtl/fib_pkg.sv
// fib_pkg: shared types and constants for the Fibonacci sequence checker
package fib_pkg;
  localparam int FIB_W = 32;
  typedef logic [FIB_W-1:0] fib_word_t;
  typedef enum logic [1:0] {EXP0, EXP1, RUN} chk_state_e;
endpackage

// File: rtl/fib_seq_checker_if.sv
// fib_seq_checker_if: input term stream and output word stream of the checker
interface fib_seq_checker_if
  import fib_pkg::*;
#(
  parameter int W = FIB_W
);
  logic         in_valid;
  logic         in_ready;
  logic         in_last;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  modport master(output in_valid, in_data, in_last, out_ready, input in_ready, out_valid, out_data);
  modport slave(input in_valid, in_data, in_last, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/fib_fifo.sv
// fib_fifo: first-word fall-through FIFO, full blocks push even when popping
module fib_fifo
  import fib_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = FIB_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  output logic         o_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  input  logic         i_pop
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic [W-1:0]  r_mem [DEPTH];
  logic          w_push, w_pop;
  assign o_ready = r_cnt != (AW+1)'(DEPTH);
  assign o_valid = r_cnt != '0;
  assign o_data  = r_mem[r_rp];
  assign w_push  = i_push & o_ready;
  assign w_pop   = i_pop & o_valid;
  // pointers wrap naturally at DEPTH; occupancy holds 0..DEPTH
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  // storage needs no reset: contents are only read while occupied
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= i_data;
endmodule

// File: rtl/fib_seq_checker.sv
// fib_seq_checker: buffers a Fibonacci term stream and flags broken sequences (optional err_cnt via FIB_CHK_STATS_EN)
module fib_seq_checker
  import fib_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = FIB_W
) (
  input  logic                 clk,
  input  logic                 reset,
  fib_seq_checker_if.slave     s,
  input  logic                 err_clr,
  output logic                 err,
  output logic                 ovf,
  output logic [W-1:0]         term_cnt
`ifdef FIB_CHK_STATS_EN
  ,
  output logic [15:0]          err_cnt
`endif
);
  chk_state_e   r_state, w_next;
  logic [W-1:0] r_prev2, r_prev;
  logic [W:0]   w_exp;
  logic         w_acc, w_mis, w_ovf;
  fib_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .i_push (s.in_valid),
    .i_data (s.in_data),
    .o_ready(s.in_ready),
    .o_valid(s.out_valid),
    .o_data (s.out_data),
    .i_pop  (s.out_ready)
  );
  assign w_acc = s.in_valid & s.in_ready;
  assign w_mis = w_acc & (s.in_data != w_exp[W-1:0]);
  assign w_ovf = w_acc & (r_state == RUN) & w_exp[W];
  // checker state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= EXP0;
    else r_state <= w_next;
  // advance position only on accept; last term restarts the sequence
  always_comb
    w_next = !w_acc ? r_state : s.in_last ? EXP0 : r_state == EXP0 ? EXP1 : RUN;
  // expected term for the current position, one extra bit to see overflow
  always_comb
    w_exp = r_state == EXP0 ? '0 : r_state == EXP1 ? {{W{1'b0}}, 1'b1} : {1'b0, r_prev2} + {1'b0, r_prev};
  // history reseeds from received data; sticky flags let a set beat a clear
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_prev2  <= '0;
      r_prev   <= '0;
      term_cnt <= '0;
      err      <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (w_acc) begin
        r_prev2  <= r_prev;
        r_prev   <= s.in_data;
        term_cnt <= s.in_last ? '0 : &term_cnt ? term_cnt : term_cnt + 1'b1;
      end
      err <= w_mis | (err & ~err_clr);
      ovf <= w_ovf | (ovf & ~err_clr);
    end
`ifdef FIB_CHK_STATS_EN
  logic [15:0] w_ecnt_base;
  assign w_ecnt_base = err_clr ? 16'h0 : err_cnt;
  // saturating mismatch count, cleared alongside the sticky flags
  always_ff @(posedge clk or negedge reset)
    if (!reset) err_cnt <= '0;
    else err_cnt <= w_mis && !(&w_ecnt_base) ? w_ecnt_base + 16'h1 : w_ecnt_base;
`endif
endmodule

// File: tb/tb_fib_seq_checker.sv
// tb_fib_seq_checker: directed vectors plus FIFO-full and mid-stream reset sequences
module tb_fib_seq_checker;
  import fib_pkg::*;
  typedef struct {
    logic      idle;
    fib_word_t d;
    logic      last;
    logic      clr;
    logic      e_err;
    logic      e_ovf;
    fib_word_t e_cnt;
    logic [15:0] e_ecnt;
  } vec_t;
  logic      clk = 0, reset = 0, err_clr = 0, err, ovf;
  fib_word_t term_cnt;
  int        checks = 0, errors = 0;
  fib_word_t q[$];
  vec_t      tv[$];
`ifdef FIB_CHK_STATS_EN
  logic [15:0] err_cnt;
`endif
  fib_seq_checker_if #(.W(32)) ifc ();
  fib_seq_checker #(.DEPTH(8), .W(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .s       (ifc),
    .err_clr (err_clr),
    .err     (err),
    .ovf     (ovf),
    .term_cnt(term_cnt)
`ifdef FIB_CHK_STATS_EN
    ,
    .err_cnt (err_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask
  function automatic vec_t v(logic i, fib_word_t d, logic l, logic c, logic e, logic o, fib_word_t n, logic [15:0] k);
    vec_t r;
    r.idle = i; r.d = d; r.last = l; r.clr = c; r.e_err = e; r.e_ovf = o; r.e_cnt = n; r.e_ecnt = k;
    return r;
  endfunction
  task automatic xfer(input fib_word_t d, input logic l, input logic c);
    logic ok = 0;
    ifc.in_valid = 1; ifc.in_data = d; ifc.in_last = l; err_clr = c;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = ifc.in_ready;
    end
    chk("accept_timeout", ok, 1);
    @(posedge clk); #1;
    ifc.in_valid = 0; ifc.in_last = 0; err_clr = 0;
  endtask
  always @(negedge clk)
    if (!reset) q.delete();
    else begin
      if (ifc.out_valid && ifc.out_ready) begin
        if (q.size() == 0) chk("pop_on_empty", 1, 0);
        else begin
          chk("out_data", ifc.out_data, q[0]);
          void'(q.pop_front());
        end
      end
      if (ifc.in_valid && ifc.in_ready) q.push_back(ifc.in_data);
    end
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    tv.push_back(v(0, 0, 0, 0, 0, 0, 1, 0));
    tv.push_back(v(0, 1, 0, 0, 0, 0, 2, 0));
    tv.push_back(v(0, 1, 0, 0, 0, 0, 3, 0));
    tv.push_back(v(0, 2, 0, 0, 0, 0, 4, 0));
    tv.push_back(v(0, 3, 0, 0, 0, 0, 5, 0));
    tv.push_back(v(0, 5, 0, 0, 0, 0, 6, 0));
    tv.push_back(v(0, 8, 1, 0, 0, 0, 0, 0));
    tv.push_back(v(0, 0, 0, 0, 0, 0, 1, 0));
    tv.push_back(v(0, 1, 0, 0, 0, 0, 2, 0));
    tv.push_back(v(0, 1, 0, 0, 0, 0, 3, 0));
    tv.push_back(v(0, 2, 0, 0, 0, 0, 4, 0));
    tv.push_back(v(0, 4, 0, 0, 1, 0, 5, 1));
    tv.push_back(v(0, 6, 1, 0, 1, 0, 0, 1));
    tv.push_back(v(0, 0, 0, 0, 1, 0, 1, 1));
    tv.push_back(v(0, 1, 0, 0, 1, 0, 2, 1));
    tv.push_back(v(0, 1, 1, 0, 1, 0, 0, 1));
    tv.push_back(v(1, 0, 0, 1, 0, 0, 0, 0));
    tv.push_back(v(0, 32'd1836311903, 0, 0, 1, 0, 1, 1));
    tv.push_back(v(0, 32'd2971215073, 0, 0, 1, 0, 2, 2));
    tv.push_back(v(1, 0, 0, 1, 0, 0, 2, 0));
    tv.push_back(v(0, 32'd512559680, 1, 0, 0, 1, 0, 0));
    tv.push_back(v(0, 7, 1, 1, 1, 0, 0, 1));
    tv.push_back(v(1, 0, 0, 1, 0, 0, 0, 0));
    ifc.in_valid = 0; ifc.in_data = 0; ifc.in_last = 0; ifc.out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", ifc.out_valid, 0);
    chk("rst_in_ready", ifc.in_ready, 1);
    chk("rst_err", err, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_term_cnt", term_cnt, 0);
    reset = 1;
    @(posedge clk); #1;
    foreach (tv[i]) begin
      if (tv[i].idle) begin
        err_clr = tv[i].clr;
        @(posedge clk); #1;
        err_clr = 0;
      end else xfer(tv[i].d, tv[i].last, tv[i].clr);
      @(negedge clk);
      chk($sformatf("err[%0d]", i), err, tv[i].e_err);
      chk($sformatf("ovf[%0d]", i), ovf, tv[i].e_ovf);
      chk($sformatf("term_cnt[%0d]", i), term_cnt, tv[i].e_cnt);
`ifdef FIB_CHK_STATS_EN
      chk($sformatf("err_cnt[%0d]", i), err_cnt, 32'(tv[i].e_ecnt));
`endif
      @(posedge clk); #1;
    end
    ifc.out_ready = 0;
    for (int i = 0; i < 8; i++) begin
      ifc.in_valid = 1; ifc.in_data = 100 + i;
      @(negedge clk);
      chk($sformatf("fill_ready[%0d]", i), ifc.in_ready, 1);
      @(posedge clk); #1;
      if (i == 0) begin
        chk("fwft_valid", ifc.out_valid, 1);
        chk("fwft_data", ifc.out_data, 100);
      end
    end
    ifc.in_data = 108;
    @(negedge clk);
    chk("full_ready", ifc.in_ready, 0);
    chk("full_valid", ifc.out_valid, 1);
    @(posedge clk); #1;
    ifc.out_ready = 1;
    @(posedge clk); #1;
    ifc.out_ready = 0;
    @(negedge clk);
    chk("after_pop_ready", ifc.in_ready, 1);
    @(posedge clk); #1;
    ifc.in_valid = 0;
    @(negedge clk);
    chk("refull_ready", ifc.in_ready, 0);
    chk("full_term_cnt", term_cnt, 9);
    @(posedge clk); #1;
    ifc.out_ready = 1;
    repeat (10) @(posedge clk);
    #1;
    chk("drained_valid", ifc.out_valid, 0);
    ifc.out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      ifc.in_valid = 1; ifc.in_data = 200 + i;
      @(posedge clk); #1;
    end
    ifc.in_valid = 0;
    ifc.out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    ifc.out_ready = 0;
    @(negedge clk);
    chk("pre_rst_valid", ifc.out_valid, 1);
    chk("pre_rst_err", err, 1);
    @(posedge clk); #1;
    reset = 0;
    #1;
    chk("mid_rst_valid", ifc.out_valid, 0);
    chk("mid_rst_ready", ifc.in_ready, 1);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_term_cnt", term_cnt, 0);
    @(posedge clk); #1;
    reset = 1;
    ifc.out_ready = 1;
    @(posedge clk); #1;
    xfer(0, 0, 0);
    @(negedge clk);
    chk("post_rst_err0", err, 0);
    @(posedge clk); #1;
    xfer(1, 0, 0);
    @(negedge clk);
    chk("post_rst_err1", err, 0);
    chk("post_rst_term_cnt", term_cnt, 2);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("sb_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
